wshb_arbiter: RTL and testbench



---
 rtl/wshb_arb_pkg.sv | 54 +++++
 rtl/wshb_if.sv | 29 ++
 rtl/wshb_arb_quota.sv | 35 +++
 rtl/wshb_arbiter.sv | 145 ++++++++++++++
 tb/tb_wshb_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/wshb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
// Holds the grant FSM encoding, bus widths and the next-grant function.
package wshb_arb_pkg;

    localparam int NB_MASTERS = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1
    } arb_state_t;

    typedef struct packed {
        logic          cyc;
        logic          stb;
        logic          we;
        logic [AW-1:0] adr;
        logic [SW-1:0] sel;
        logic [DW-1:0] dat;
        logic [2:0]    cti;
        logic [1:0]    bte;
    } wb_req_t;

    // last = 1 means master 1 held the bus most recently
    function automatic arb_state_t arb_next(
        input arb_state_t s,
        input logic       last,
        input logic       cyc0,
        input logic       req0,
        input logic       cyc1,
        input logic       req1
    );
        arb_state_t n;
        n = s;
        unique case (s)
            IDLE: begin
                if (req0 && req1)
                    n = last ? GNT0 : GNT1;
                else if (req0)
                    n = GNT0;
                else if (req1)
                    n = GNT1;
            end
            GNT0: if (!cyc0) n = req1 ? GNT1 : IDLE;
            GNT1: if (!cyc1) n = req0 ? GNT0 : IDLE;
            default: n = IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 classic/registered-feedback bundle.
// master/slave modports are named from the owning module's side.
interface wshb_if;
    import wshb_arb_pkg::*;

    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [SW-1:0] sel;
    logic [DW-1:0] dat_ms;
    logic [DW-1:0] dat_sm;
    logic          ack;
    logic          err;
    logic          rty;
    logic [2:0]    cti;
    logic [1:0]    bte;

    modport master (
        output cyc, stb, we, adr, sel, dat_ms, cti, bte,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_ms, cti, bte,
        output dat_sm, ack, err, rty
    );

endinterface

// File: rtl/wshb_arb_quota.sv
// Per-grant ack counter and bus-permission token, shared by both grants.
// token falls on the edge after the ack that reaches quota (0 = unlimited).
module wshb_arb_quota
    import wshb_arb_pkg::*;
#(
    parameter int QW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    input  logic [QW-1:0] quota,
    output logic          token
);

    logic [QW-1:0] cnt;
    logic [QW-1:0] cnt_inc;

    assign cnt_inc = cnt + {{(QW-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            token <= 1'b1;
        end else if (clear) begin
            cnt   <= '0;
            token <= 1'b1;
        end else if (inc) begin
            cnt <= cnt_inc;
            if (quota != '0 && cnt_inc == quota)
                token <= 1'b0;
        end
    end

endmodule

// File: rtl/wshb_arbiter.sv
// Round-robin 2:1 Wishbone arbiter with per-master ack quota.
// Define WSHB_ARBITER_STATS_EN to enable the 32-bit per-port ack counters.
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int QUOTA0 = 64,
    parameter int QUOTA1 = 16,
    parameter int QW     = 16
) (
    input  logic        clk,
    input  logic        rst,
    wshb_if.slave       wshb_ifs0,
    wshb_if.slave       wshb_ifs1,
    wshb_if.master      wshb_ifm,
    output logic        token0,
    output logic        token1,
    output logic [31:0] ack_cnt0,
    output logic [31:0] ack_cnt1
);

    localparam logic [QW-1:0] Q0 = QW'(QUOTA0);
    localparam logic [QW-1:0] Q1 = QW'(QUOTA1);

    arb_state_t state;
    arb_state_t nxt;
    logic       last_gnt;
    logic       req0, req1;
    logic       g0, g1;
    logic       enter;
    logic       inc;
    logic       tok;
    wb_req_t    r0, r1, rm;

    assign req0 = wshb_ifs0.cyc & wshb_ifs0.stb;
    assign req1 = wshb_ifs1.cyc & wshb_ifs1.stb;
    assign g0   = (state == GNT0);
    assign g1   = (state == GNT1);

    assign nxt = arb_next(state, last_gnt,
                          wshb_ifs0.cyc, req0,
                          wshb_ifs1.cyc, req1);

    assign enter = (nxt != state) && (nxt != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state <= nxt;
            if (enter)
                last_gnt <= (nxt == GNT1);
        end
    end

    // Acks with the granted stb low are not real transfers
    assign inc = wshb_ifm.ack &
                 ((g0 & wshb_ifs0.stb) | (g1 & wshb_ifs1.stb));

    wshb_arb_quota #(
        .QW(QW)
    ) u_quota (
        .clk  (clk),
        .rst  (rst),
        .clear(enter),
        .inc  (inc),
        .quota(g1 ? Q1 : Q0),
        .token(tok)
    );

    assign token0 = ~(g0 & ~tok);
    assign token1 = ~(g1 & ~tok);

    assign r0 = '{
        cyc: wshb_ifs0.cyc,
        stb: wshb_ifs0.stb,
        we:  wshb_ifs0.we,
        adr: wshb_ifs0.adr,
        sel: wshb_ifs0.sel,
        dat: wshb_ifs0.dat_ms,
        cti: wshb_ifs0.cti,
        bte: wshb_ifs0.bte
    };

    assign r1 = '{
        cyc: wshb_ifs1.cyc,
        stb: wshb_ifs1.stb,
        we:  wshb_ifs1.we,
        adr: wshb_ifs1.adr,
        sel: wshb_ifs1.sel,
        dat: wshb_ifs1.dat_ms,
        cti: wshb_ifs1.cti,
        bte: wshb_ifs1.bte
    };

    always_comb begin
        rm = '0;
        unique case (1'b1)
            g0:      rm = r0;
            g1:      rm = r1;
            default: rm = '0;
        endcase
    end

    assign wshb_ifm.cyc    = rm.cyc;
    assign wshb_ifm.stb    = rm.stb;
    assign wshb_ifm.we     = rm.we;
    assign wshb_ifm.adr    = rm.adr;
    assign wshb_ifm.sel    = rm.sel;
    assign wshb_ifm.dat_ms = rm.dat;
    assign wshb_ifm.cti    = rm.cti;
    assign wshb_ifm.bte    = rm.bte;

    assign wshb_ifs0.ack    = g0 & wshb_ifm.ack;
    assign wshb_ifs1.ack    = g1 & wshb_ifm.ack;
    assign wshb_ifs0.err    = g0 & wshb_ifm.err;
    assign wshb_ifs1.err    = g1 & wshb_ifm.err;
    assign wshb_ifs0.rty    = g0 & wshb_ifm.rty;
    assign wshb_ifs1.rty    = g1 & wshb_ifm.rty;
    assign wshb_ifs0.dat_sm = wshb_ifm.dat_sm;
    assign wshb_ifs1.dat_sm = wshb_ifm.dat_sm;

`ifdef WSHB_ARBITER_STATS_EN
    logic [31:0] cnt0, cnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (g0 & wshb_ifs0.stb & wshb_ifm.ack)
                cnt0 <= cnt0 + 32'd1;
            if (g1 & wshb_ifs1.stb & wshb_ifm.ack)
                cnt1 <= cnt1 + 32'd1;
        end
    end

    assign ack_cnt0 = cnt0;
    assign ack_cnt1 = cnt1;
`else
    assign ack_cnt0 = '0;
    assign ack_cnt1 = '0;
`endif

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed bench for wshb_arbiter with QUOTA0=4 and QUOTA1=0.
// Masters gate cyc/stb by token; the slave acks every strobed cycle.
module tb_wshb_arbiter;
    import wshb_arb_pkg::*;

    localparam logic [31:0] ADR0 = 32'h0000_0A00;
    localparam logic [31:0] ADR1 = 32'h1000_0B00;
    localparam logic [31:0] SDAT = 32'hCAFE_F00D;

`ifdef WSHB_ARBITER_STATS_EN
    localparam int EXP_C0 = 37;
    localparam int EXP_C1 = 5;
`else
    localparam int EXP_C0 = 0;
    localparam int EXP_C1 = 0;
`endif

    logic        clk;
    logic        rst;
    logic        want0, want1;
    logic        token0, token1;
    logic [31:0] ack_cnt0, ack_cnt1;
    int          n0 = 0;
    int          n1 = 0;
    int          checks = 0;
    int          errors = 0;

    wshb_if ifs0 ();
    wshb_if ifs1 ();
    wshb_if ifm ();

    assign ifs0.cyc    = want0 & token0;
    assign ifs0.stb    = want0 & token0;
    assign ifs0.we     = 1'b0;
    assign ifs0.adr    = ADR0;
    assign ifs0.sel    = 4'hF;
    assign ifs0.dat_ms = '0;
    assign ifs0.cti    = 3'd0;
    assign ifs0.bte    = 2'd0;

    assign ifs1.cyc    = want1 & token1;
    assign ifs1.stb    = want1 & token1;
    assign ifs1.we     = 1'b1;
    assign ifs1.adr    = ADR1;
    assign ifs1.sel    = 4'h3;
    assign ifs1.dat_ms = 32'h1234_5678;
    assign ifs1.cti    = 3'd0;
    assign ifs1.bte    = 2'd0;

    assign ifm.ack    = ifm.cyc & ifm.stb;
    assign ifm.err    = 1'b0;
    assign ifm.rty    = 1'b0;
    assign ifm.dat_sm = SDAT;

    wshb_arbiter #(
        .QUOTA0(4),
        .QUOTA1(0),
        .QW    (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wshb_ifs0(ifs0),
        .wshb_ifs1(ifs1),
        .wshb_ifm (ifm),
        .token0   (token0),
        .token1   (token1),
        .ack_cnt0 (ack_cnt0),
        .ack_cnt1 (ack_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Acks seen by each master at the edge the DUT samples them
    always @(posedge clk) begin
        if (ifs0.ack) n0 <= n0 + 1;
        if (ifs1.ack) n1 <= n1 + 1;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic run_m0(input int n, input string tag);
        int b;
        b = n0;
        want0 = 1'b1;
        for (int i = 0; i < 1000 && (n0 - b) != n; i++)
            @(negedge clk);
        want0 = 1'b0;
        check(tag, n0 - b, n);
    endtask

    task automatic run_m1(input int n, input string tag);
        int b;
        b = n1;
        want1 = 1'b1;
        for (int i = 0; i < 1000 && (n1 - b) != n; i++)
            @(negedge clk);
        want1 = 1'b0;
        check(tag, n1 - b, n);
    endtask

    initial begin
        int b0, b1;
        logic bad0, tkbad;
        rst   = 1'b1;
        want0 = 1'b0;
        want1 = 1'b0;
        tick(3);
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("idle_tok0", token0, 1);
            check("idle_tok1", token1, 1);
            check("idle_cyc", ifm.cyc, 0);
        end
        check("rst_cnt0", ack_cnt0, 0);
        check("rst_cnt1", ack_cnt1, 0);

        // Master 0 alone, quota of 4
        b0 = n0;
        want0 = 1'b1;
        tick(1);
        check("q_grant_cyc", ifm.cyc, 1);
        check("q_grant_adr", ifm.adr, ADR0);
        for (int i = 0; i < 20 && token0; i++) tick(1);
        check("q_tok_drop", token0, 0);
        check("q_acks", n0 - b0, 4);
        check("q_no_ack", ifs0.ack, 0);
        tick(1);
        check("q_rel_cyc", ifm.cyc, 0);
        check("q_tok_back", token0, 1);
        tick(1);
        check("q_regrant", ifm.cyc, 1);
        check("q_regrant_ack", ifs0.ack, 1);
        want0 = 1'b0;
        tick(2);

        // Simultaneous request: m0 first, then m1 back-to-back
        pulse_rst();
        want0 = 1'b1;
        want1 = 1'b1;
        tick(1);
        check("both_adr0", ifm.adr, ADR0);
        check("both_ack0", ifs0.ack, 1);
        check("both_ack1", ifs1.ack, 0);
        want0 = 1'b0;
        tick(1);
        check("sw_cyc", ifm.cyc, 1);
        check("sw_adr1", ifm.adr, ADR1);
        check("sw_we", ifm.we, 1);
        check("sw_ack0", ifs0.ack, 0);
        check("sw_ack1", ifs1.ack, 1);
        check("sw_bcast", ifs0.dat_sm, SDAT);

        // m1 unlimited burst of 100 while m0 waits
        want0 = 1'b1;
        b0 = n0;
        b1 = n1;
        bad0 = 1'b0;
        tkbad = 1'b0;
        for (int i = 0; i < 300 && (n1 - b1) != 100; i++) begin
            tick(1);
            bad0  = bad0 | ifs0.ack;
            tkbad = tkbad | ~token1;
        end
        want1 = 1'b0;
        check("m1_acks", n1 - b1, 100);
        check("m1_tok", tkbad, 0);
        check("m0_wait_ack", bad0, 0);
        check("m0_wait_cnt", n0 - b0, 0);
        tick(1);
        check("m0_after", ifs0.ack, 1);
        check("m0_after_adr", ifm.adr, ADR0);
        want0 = 1'b0;
        tick(2);

        // Reset in the middle of a burst
        pulse_rst();
        b0 = n0;
        want0 = 1'b1;
        for (int i = 0; i < 20 && (n0 - b0) != 2; i++) tick(1);
        check("mid_acks", n0 - b0, 2);
        rst = 1'b1;
        tick(1);
        check("mid_cyc", ifm.cyc, 0);
        check("mid_tok0", token0, 1);
        check("mid_tok1", token1, 1);
        check("mid_cnt0", ack_cnt0, 0);
        rst = 1'b0;
        b0 = n0;
        for (int i = 0; i < 20 && token0; i++) tick(1);
        check("mid_quota", n0 - b0, 4);
        want0 = 1'b0;
        tick(2);

        // Per-port ack statistics
        pulse_rst();
        run_m0(37, "st_m0_run");
        tick(2);
        run_m1(5, "st_m1_run");
        tick(2);
        check("st_cnt0", ack_cnt0, EXP_C0);
        check("st_cnt1", ack_cnt1, EXP_C1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
